// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with occupancy, thresholds and sticky error flags
//
// Purpose:
//   Buffers WIDTH-bit words between vend-event producers and the dispense/change
//   controller. DEPTH entries. Occupancy count, exact full/empty flags, and programmable
//   almost-full/almost-empty thresholds are all registered. Dropped writes set
//   overflow and dropped reads set underflow. Both flags are sticky until clr_err.
//   FWFT selects how reads behave. FWFT=0 gives a registered read, where dout updates
//   on the edge after rd. FWFT=1 gives first-word-fall-through, where dout shows the
//   head word whenever the FIFO is not empty.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous reset, active-high
//   wr, din      write request and write data
//   rd           read request (FWFT=1: pop of the word on dout)
//   clr_err      synchronous clear of overflow/underflow
//   dout         read data
//   wrptr/rdptr  next slot to write / read
//   count        occupancy, 0..DEPTH
//   full, empty, almostfull, almostempty   registered status flags
//   overflow, underflow                    sticky error flags

module param_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic [AW-1:0]    wrptr,
    output logic [AW-1:0]    rdptr,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             almostfull,
    output logic             almostempty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_TH    = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [AW:0] AE_TH    = (AW+1)'(AE_MARGIN);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dout_q;
    logic             wr_ok;
    logic             rd_ok;
    logic             ovf_evt;
    logic             unf_evt;
    logic [AW:0]      count_nxt;

    // A write into a full FIFO is still accepted when a read frees the slot on
    // the same edge. full implies not empty, so that read is always accepted.
    // Emptiness is judged on pre-edge state, so a read of an empty FIFO is
    // dropped even when a write arrives on the same edge.
    always_comb begin
        wr_ok     = wr & (~full | rd);
        rd_ok     = rd & ~empty;
        ovf_evt   = wr & full & ~rd;
        unf_evt   = rd & empty;
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage is deliberately not reset. Reset clears the pointers and count,
    // and that alone discards the old contents.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wrptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrptr       <= '0;
            rdptr       <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almostfull  <= 1'b0;
            almostempty <= 1'b1;
            dout_q      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            // Pointers are AW bits wide, so incrementing wraps DEPTH-1 -> 0.
            if (wr_ok) begin
                wrptr <= wrptr + 1'b1;
            end
            // At full with wr&rd, wrptr==rdptr. The non-blocking read picks up
            // the old word before the write replaces it.
            if (rd_ok) begin
                rdptr  <= rdptr + 1'b1;
                dout_q <= mem[rdptr];
            end
            count <= count_nxt;

            // The flags are computed from the next count, so they line up with
            // count after the edge. There is no combinational path from wr or rd.
            full        <= (count_nxt == FULL_CNT);
            empty       <= (count_nxt == '0);
            almostfull  <= (count_nxt >= AF_TH);
            almostempty <= (count_nxt <= AE_TH);

            // If a new error and clr_err arrive on the same edge, the new error wins.
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (unf_evt) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    // In FWFT mode the head word is shown whenever the FIFO holds data.
    // When it is empty, dout shows the last popped word, or 0 after reset.
    // empty, rdptr and mem are all registered, so dout still has no path from wr or rd.
    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty ? dout_q : mem[rdptr];
        end else begin : g_reg
            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's 8-bit/16-deep buffer, generalised in data width, depth and almost-full/almost-empty thresholds. It adds an occupancy count, exact full/empty flags, sticky overflow/underflow error flags with a clear input, and a selectable first-word-fall-through read mode. It sits between vend-event producers (coin/selection logic) and consumers (dispense/change controller).

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AW, 4, pointer width; must equal log2(DEPTH)
AF_MARGIN, 2, almostfull asserts when count >= DEPTH-AF_MARGIN
AE_MARGIN, 2, almostempty asserts when count <= AE_MARGIN
FWFT, 0, 0 = registered read (dout valid 1 cycle after rd); 1 = first-word-fall-through

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous reset, active-high
wr  input  1  write request; din captured on the same edge
rd  input  1  read request (FWFT=1: acknowledge/pop of the word on dout)
din  input  WIDTH  write data
clr_err  input  1  synchronous clear of overflow/underflow
dout  output  WIDTH  read data
wrptr  output  AW  write pointer (next slot to write)
rdptr  output  AW  read pointer (next slot to read)
count  output  AW+1  occupancy, 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0
almostfull  output  1  count >= DEPTH-AF_MARGIN
almostempty  output  1  count <= AE_MARGIN
overflow  output  1  sticky: a write was dropped
underflow  output  1  sticky: a read was dropped

Behaviour:
- Reset (async, immediate): wrptr=0, rdptr=0, count=0, empty=1, full=0, almostempty=1, almostfull=0, dout=0, overflow=0, underflow=0. Memory array is not reset. Reset mid-operation discards all contents; the first read after release returns the first post-reset write.
- Flags full, empty, almostfull and almostempty are registered. They reflect count after the edge, with no combinational path from wr/rd.
- Accepted write (wr & ~full) or (wr & full & rd): mem[wrptr]<=din; wrptr increments, wrapping DEPTH-1 -> 0.
- Accepted read (rd & ~empty): rdptr increments, wrapping.
  - FWFT=0: dout<=mem[rdptr] on the same edge, so data appears 1 cycle after rd.
  - FWFT=1: dout continuously shows mem[rdptr] whenever ~empty; rd pops it and the next word shows after the edge.
- Dropped read (rd & empty): no pointer change; dout holds its last value; underflow<=1. A simultaneous wr still proceeds. Empty is judged on pre-edge state, so the read is not served from the incoming word.
- Dropped write (wr & full & ~rd): no change to memory or pointers; overflow<=1.
- Simultaneous wr & rd while 0<count<DEPTH: both proceed and count is unchanged.
- Simultaneous wr & rd at full: both proceed; count stays DEPTH and full stays 1.
- count changes as follows: +1 on write-only, -1 on read-only, unchanged on both or neither. count never exceeds DEPTH or goes below 0.
- overflow/underflow stay set until clr_err=1 at an edge or rst. If clr_err and a new error occur on the same edge, the new error wins (flag stays 1).
- Pointers wrap modulo DEPTH. full/empty derive from count, not from pointer equality.
- Inputs are sampled on the rising edge only. The bench must drive them non-blocking or away from the edge.

Test Plan:
- Reset, then idle 5 cycles -> count=0, empty=1, almostempty=1, full=0, dout=0, wrptr=rdptr=0.
- Write 0x11..0x1E (14 words, DEPTH=16, AF_MARGIN=2) -> almostfull rises after the 14th write. Write 0x1F, 0x20 -> full=1, count=16, wrptr=0 (wrapped). A 17th write of 0xAA -> overflow=1, count stays 16.
- From full, read 16 times, FWFT=0 -> dout sequence 0x11..0x20, each 1 cycle after rd. almostempty asserts at count=2, empty at count=0. A 17th rd -> underflow=1 and dout stays 0x20.
- Preload 8 words, then assert wr&rd for 10 consecutive cycles -> count stays 8, FIFO order preserved, pointers wrap with no flag change.
- FWFT=1: write 0x5A into the empty FIFO -> dout=0x5A the cycle after the write edge with no rd. rd pops it -> empty=1.
- Pulse clr_err -> overflow=underflow=0. Assert rst mid-stream with count=5 -> all outputs return to reset values immediately; the next write/read returns the new datum.
